mem_viewer: RTL and testbench

- Debug reader that takes over the single memory port from the cpu and reads words out one at a time for display.
- The cpu is the writer/initiator on that port; this block is the passive-inspection reader at the other end.
- Sits between cpu and memory as a port mux. Exposes the inspected address and word to the display path (bcd/ssd).

---
 rtl/mem_viewer_pkg.sv | 17 +
 rtl/mem_port_mux.sv | 20 ++
 rtl/mem_viewer.sv | 96 +++++++++
 tb/tb_mem_viewer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_viewer_pkg.sv
// Shared FSM encoding and timing constants for the memory viewer.
package mem_viewer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PARK = 3'd1,
        ADDR = 3'd2,
        WAIT = 3'd3,
        CAPT = 3'd4,
        SHOW = 3'd5
    } state_t;

    // Memory read data is valid this many cycles after the address is presented.
    localparam int READ_LATENCY = 1;
    localparam int WAIT_W       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

endpackage

// File: rtl/mem_port_mux.sv
// Memory port select between the cpu and the debug viewer; the viewer only ever reads.
module mem_port_mux #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sel_view,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic [ADDR_WIDTH-1:0] view_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
);

    assign mem_we   = sel_view ? 1'b0 : cpu_we;
    assign mem_addr = sel_view ? view_addr : cpu_addr;
    assign mem_data = sel_view ? '0 : cpu_data;

endmodule

// File: rtl/mem_viewer.sv
// Debug reader: parks the cpu, takes the memory port and reads one word at a time for display.
module mem_viewer
    import mem_viewer_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  step,
    input  logic                  dir,
    input  logic                  cpu_ack,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  stall,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] view_addr,
    output logic [DATA_WIDTH-1:0] view_data,
    output logic                  view_valid
);

    state_t              state, next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_done;
    logic                sel_view;

    assign wait_done = (wait_cnt == WAIT_W'(READ_LATENCY - 1));
    assign stall     = (state != IDLE);
    assign sel_view  = (state == ADDR) || (state == WAIT) || (state == CAPT) || (state == SHOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            view_addr  <= '0;
            view_data  <= '0;
            view_valid <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ADDR: wait_cnt <= '0;
                WAIT: wait_cnt <= wait_cnt + 1'b1;
                CAPT: begin
                    view_data  <= mem_out;
                    view_valid <= 1'b1;
                end
                SHOW: if (step) begin
                    // Natural wrap of the unsigned add/sub gives modulo 2^ADDR_WIDTH.
                    view_addr  <= dir ? view_addr - 1'b1 : view_addr + 1'b1;
                    view_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (en) next_state = PARK;
            PARK: begin
                if (!en)          next_state = IDLE;
                else if (cpu_ack) next_state = ADDR;
            end
            ADDR: next_state = WAIT;
            WAIT: if (wait_done) next_state = CAPT;
            CAPT: next_state = SHOW;
            // A read in flight always finishes to SHOW before the cpu is released.
            SHOW: begin
                if (step)     next_state = ADDR;
                else if (!en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    mem_port_mux #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel_view (sel_view),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .view_addr(view_addr),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

endmodule

// File: tb/tb_mem_viewer.sv
// Directed bench for mem_viewer: table-driven cycle vectors plus handover, late-release and reset sequences.
module tb_mem_viewer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, step, dir, cpu_ack, cpu_we;
    logic [5:0]  cpu_addr;
    logic [15:0] cpu_data;
    logic [15:0] mem_out;
    logic        stall, mem_we, view_valid;
    logic [5:0]  mem_addr, view_addr;
    logic [15:0] mem_data, view_data;

    logic [15:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [15:0] bd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid one cycle after the address.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    mem_viewer #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .step(step), .dir(dir), .cpu_ack(cpu_ack),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .mem_out(mem_out),
        .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .view_addr(view_addr), .view_data(view_data), .view_valid(view_valid)
    );

    typedef struct {
        logic        en, step, dir, ack, we;
        logic        stall, sel;
        logic [5:0]  vaddr;
        logic        chk_v, valid, chk_d;
        logic [15:0] vdata;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic e, logic s, logic d, logic a, logic w, logic st, logic sl,
                                logic [5:0] va, logic cv, logic v, logic cd, logic [15:0] vd);
        vec_t r;
        r.en = e; r.step = s; r.dir = d; r.ack = a; r.we = w;
        r.stall = st; r.sel = sl; r.vaddr = va;
        r.chk_v = cv; r.valid = v; r.chk_d = cd; r.vdata = vd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [5:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 0; step = 0; dir = 0; cpu_ack = 0; cpu_we = 0;
        cpu_addr = 6'd5; cpu_data = 16'hC0DE;
        bd_we = 0; bd_addr = 0; bd_data = 0;

        // en, step, dir, ack, we | stall, sel, vaddr, chk_v, valid, chk_d, vdata
        vecs[0]  = mk(1,0,0,0,0, 1,0, 6'd0,  1,0, 0,16'h0);     // PARK
        vecs[1]  = mk(1,0,0,1,1, 1,1, 6'd0,  1,0, 0,16'h0);     // ADDR
        vecs[2]  = mk(1,0,0,1,1, 1,1, 6'd0,  1,0, 0,16'h0);     // WAIT
        vecs[3]  = mk(1,0,0,0,1, 1,1, 6'd0,  1,0, 0,16'h0);     // CAPT, ack drop ignored
        vecs[4]  = mk(1,0,0,0,1, 1,1, 6'd0,  1,1, 1,16'h1234);  // SHOW
        vecs[5]  = mk(1,0,0,1,1, 1,1, 6'd0,  1,1, 1,16'h1234);
        vecs[6]  = mk(1,1,1,1,1, 1,1, 6'd63, 1,0, 0,16'h0);     // step -1 wraps to 63
        vecs[7]  = mk(1,0,0,1,1, 1,1, 6'd63, 1,0, 0,16'h0);
        vecs[8]  = mk(1,0,0,1,1, 1,1, 6'd63, 1,0, 0,16'h0);
        vecs[9]  = mk(1,0,0,1,1, 1,1, 6'd63, 1,1, 1,16'hBEEF);
        vecs[10] = mk(1,1,0,1,1, 1,1, 6'd0,  1,0, 0,16'h0);     // step +1 wraps to 0
        vecs[11] = mk(1,0,0,1,1, 1,1, 6'd0,  1,0, 0,16'h0);
        vecs[12] = mk(1,0,0,1,1, 1,1, 6'd0,  1,0, 0,16'h0);
        vecs[13] = mk(1,0,0,1,1, 1,1, 6'd0,  1,1, 1,16'h1234);
        vecs[14] = mk(1,1,0,1,1, 1,1, 6'd1,  1,0, 0,16'h0);     // ADDR @1
        vecs[15] = mk(1,0,0,1,1, 1,1, 6'd1,  1,0, 0,16'h0);     // WAIT
        vecs[16] = mk(1,1,0,1,1, 1,1, 6'd1,  1,0, 0,16'h0);     // step in WAIT ignored
        vecs[17] = mk(1,0,0,1,1, 1,1, 6'd1,  1,1, 1,16'h5A5A);
        vecs[18] = mk(1,0,0,1,1, 1,1, 6'd1,  1,1, 1,16'h5A5A);
        vecs[19] = mk(0,0,0,1,0, 0,0, 6'd1,  0,0, 0,16'h0);     // IDLE
        vecs[20] = mk(0,1,0,0,0, 0,0, 6'd1,  0,0, 0,16'h0);     // step in IDLE ignored
        vecs[21] = mk(1,0,0,0,0, 1,0, 6'd1,  0,0, 0,16'h0);     // PARK again
        vecs[22] = mk(1,0,0,1,0, 1,1, 6'd1,  0,0, 0,16'h0);     // re-read same address
        vecs[23] = mk(1,0,0,1,0, 1,1, 6'd1,  0,0, 0,16'h0);
        vecs[24] = mk(1,0,0,1,0, 1,1, 6'd1,  0,0, 0,16'h0);
        vecs[25] = mk(1,0,0,1,0, 1,1, 6'd1,  1,1, 1,16'h5A5A);

        tick();
        bd_write(6'd0,  16'h1234);
        bd_write(6'd1,  16'h5A5A);
        bd_write(6'd63, 16'hBEEF);

        chk("rst_stall",      {31'd0, stall},      32'd0);
        chk("rst_view_addr",  {26'd0, view_addr},  32'd0);
        chk("rst_view_valid", {31'd0, view_valid}, 32'd0);
        chk("rst_view_data",  {16'd0, view_data},  32'd0);
        chk("rst_mem_addr",   {26'd0, mem_addr},   32'd5);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 26; i++) begin
            en = vecs[i].en; step = vecs[i].step; dir = vecs[i].dir;
            cpu_ack = vecs[i].ack; cpu_we = vecs[i].we;
            tick();
            chk($sformatf("v%0d_stall", i),    {31'd0, stall},  {31'd0, vecs[i].stall});
            chk($sformatf("v%0d_mem_addr", i), {26'd0, mem_addr},
                {26'd0, vecs[i].sel ? vecs[i].vaddr : cpu_addr});
            chk($sformatf("v%0d_mem_we", i),   {31'd0, mem_we},
                {31'd0, vecs[i].sel ? 1'b0 : cpu_we});
            chk($sformatf("v%0d_mem_data", i), {16'd0, mem_data},
                {16'd0, vecs[i].sel ? 16'h0 : cpu_data});
            chk($sformatf("v%0d_view_addr", i), {26'd0, view_addr}, {26'd0, vecs[i].vaddr});
            if (vecs[i].chk_v)
                chk($sformatf("v%0d_view_valid", i), {31'd0, view_valid}, {31'd0, vecs[i].valid});
            if (vecs[i].chk_d)
                chk($sformatf("v%0d_view_data", i), {16'd0, view_data}, {16'd0, vecs[i].vdata});
        end
        step = 0;

        // Leave view mode, then hold the cpu in PARK without ack while it writes.
        en = 0; tick();
        chk("exit_stall", {31'd0, stall}, 32'd0);
        cpu_addr = 6'd10; cpu_data = 16'hABCD; cpu_we = 1; en = 1; cpu_ack = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("park%0d", c), {29'd0, stall, mem_we, (mem_addr == 6'd10)}, 32'd7);
        end
        chk("park_write", {16'd0, mem[10]}, 32'h0000ABCD);
        en = 0; cpu_we = 0; tick();
        chk("park_drop_stall", {31'd0, stall}, 32'd0);
        chk("park_drop_addr", {26'd0, mem_addr}, 32'd10);

        // Late release: en drops once the FSM is in ADDR.
        cpu_addr = 6'd5;
        bd_write(6'd1, 16'h7777);
        en = 1; cpu_ack = 1; tick();
        chk("late_park", {31'd0, stall}, 32'd1);
        tick();
        chk("late_addr", {26'd0, mem_addr}, 32'd1);
        en = 0;
        tick(); chk("late_wait_stall", {31'd0, stall}, 32'd1);
        tick(); chk("late_capt_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("late_show_stall", {31'd0, stall}, 32'd1);
        chk("late_show_valid", {31'd0, view_valid}, 32'd1);
        chk("late_show_data", {16'd0, view_data}, 32'h00007777);
        tick();
        chk("late_idle_stall", {31'd0, stall}, 32'd0);

        // Asynchronous reset while in SHOW.
        en = 1; cpu_ack = 1;
        for (int c = 0; c < 5; c++) tick();
        chk("pre_rst_valid", {31'd0, view_valid}, 32'd1);
        cpu_addr = 6'd33; cpu_we = 1;
        rst = 1; #1;
        chk("arst_stall",      {31'd0, stall},      32'd0);
        chk("arst_mem_addr",   {26'd0, mem_addr},   32'd33);
        chk("arst_mem_we",     {31'd0, mem_we},     32'd1);
        chk("arst_view_addr",  {26'd0, view_addr},  32'd0);
        chk("arst_view_valid", {31'd0, view_valid}, 32'd0);
        chk("arst_view_data",  {16'd0, view_data},  32'd0);
        cpu_we = 0; en = 0;
        tick();
        rst = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
